irrigation_ctrl: RTL and testbench
==================================

IRRIGATION_CTRL -- requirements
Module: irrigation_ctrl

Interface
REQ-001 Parameter NZONES, default 4: number of irrigation zones, 1..8.
REQ-002 Parameter SPR_CYC, default 1000: sprinkler run length in clock cycles, >=1.
REQ-003 Parameter DRIP_CYC, default 4000: drip run length in clock cycles, >=1.
REQ-004 Parameter FILL_TIMEOUT, default 50000: maximum inlet-valve open time in cycles, >=1.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port clk, input, 1: system clock, rising edge.
REQ-007 Port rst_n, input, 1: asynchronous active-low reset.
REQ-008 Port H, M, L, inputs, 1 each: tank high/mid/low level sensors, 1 = water present at that level.
REQ-009 Port Ua, input, 1: air dry flag. Port T, input, 1: high-temperature flag.
REQ-010 Port Us, input, NZONES: per-zone soil-wet flag, 1 = wet.
REQ-011 Port Ve, output, 1: inlet valve open.
REQ-012 Port Bs, output, NZONES: per-zone sprinkler pump on.
REQ-013 Port Vs, output, NZONES: per-zone drip valve open.
REQ-014 Port Al, output, 1: alarm. Port E, output, 1: error.
REQ-015 Port zone, output, max(1,clog2(NZONES)): current zone pointer.

Function
REQ-016 All inputs except clk and rst_n SHALL pass a 2-flop synchroniser; all outputs SHALL be registered.
REQ-017 A level input change SHALL be visible on Ve/Al/E exactly 3 rising edges after it is applied.
REQ-018 Level code invalid = (H & ~M) | (M & ~L); E SHALL assert while the synchronised code is invalid.
REQ-019 Al SHALL equal E | ~L, computed from the synchronised inputs.
REQ-020 Ve SHALL set when M=0 and E=0, clear when H=1 or E=1, and hold otherwise (hysteresis).
REQ-021 The irrigation FSM SHALL have states IDLE, SPRINKLE, DRIP, and PAUSE.
REQ-022 IDLE, zone[ptr] wet or Al=1: ptr SHALL advance by 1 per cycle (wrap NZONES-1->0) if wet; if Al=1 it SHALL hold.
REQ-023 IDLE, zone[ptr] dry and Al=0: go to DRIP if Ua=1 and T=1, else SPRINKLE; load timer.
REQ-024 In SPRINKLE, Bs[ptr] SHALL be 1. In DRIP, Vs[ptr] SHALL be 1. All other Bs/Vs bits SHALL be 0.
REQ-025 Run ends when the timer reaches SPR_CYC (SPRINKLE) or DRIP_CYC (DRIP), or when Us[ptr] becomes 1; the FSM then goes to PAUSE.
REQ-026 PAUSE SHALL last exactly 1 cycle with all Bs/Vs at 0, advance ptr, then return to IDLE.
REQ-027 Al rising during SPRINKLE/DRIP SHALL clear Bs/Vs on the next edge and return to IDLE without advancing ptr; the zone is retried after Al clears.
REQ-028 At no time SHALL more than one bit across Bs and Vs be 1.
REQ-029 A dry zone whose sensor stays dry SHALL run exactly SPR_CYC or DRIP_CYC cycles.
REQ-030 The mode is fixed at run start; Ua/T changes mid-run SHALL NOT switch the mode.

Reset
REQ-031 While rst_n=0: Ve, Bs, Vs, Al, E = 0; zone = 0; FSM = IDLE; timers = 0; synchroniser flops = 0.
REQ-032 Reset asserted mid-run SHALL drop all outputs immediately (asynchronously), not at the next edge.
REQ-033 After rst_n deasserts, the first outputs derived from inputs SHALL appear 3 edges later.

Configuration
REQ-034 Macro IRRIG_FILL_TIMEOUT_EN defined: a fill counter SHALL count cycles with Ve=1.
REQ-035 If that counter reaches FILL_TIMEOUT, E SHALL latch to 1 and Ve to 0 until reset.
REQ-036 Macro IRRIG_FILL_TIMEOUT_EN undefined: no fill counter; E reflects the level code only.

Verification (NZONES=2, SPR_CYC=4, DRIP_CYC=6, FILL_TIMEOUT=10)
REQ-037 Stimulus: H,M,L=0,0,1, Us=2'b11. Response: Ve=1 after 3 edges; H,M,L=1,1,1 -> Ve=0 after 3 edges.
REQ-038 Stimulus: H,M,L=1,0,1. Response: E=1, Al=1, Ve=0; with H,M,L=1,1,1 and Us=2'b00, Bs and Vs stay 0 until the code becomes valid.
REQ-039 Stimulus: H,M,L=1,1,1, Ua=0, Us=2'b10. Response: Bs=2'b01 for exactly 4 cycles, 1 PAUSE cycle, zone=1, then zone advances to 0.
REQ-040 Stimulus: Ua=1, T=1, Us=2'b00. Response: Vs=2'b01 for 6 cycles, pause, then Vs=2'b10 for 6 cycles; Bs=0 throughout.
REQ-041 Stimulus: L drops to 0 on cycle 2 of a sprinkle. Response: Al=1 and Bs=0 within 3 edges; zone unchanged; on L=1 the same zone restarts with a full 4 cycles.
REQ-042 Stimulus (IRRIG_FILL_TIMEOUT_EN): M=0, H never rises. Response: Ve=1 for 10 cycles, then Ve=0 and E=1 held until rst_n pulses low.

Source files
------------

// File: rtl/irrigation_ctrl.sv
// irrigation_ctrl: tank inlet hysteresis, level alarm/error and zone sprinkle/drip sequencer; IRRIG_FILL_TIMEOUT_EN adds a latching fill timeout
module irrigation_ctrl #(
  parameter int NZONES       = 4,
  parameter int SPR_CYC      = 1000,
  parameter int DRIP_CYC     = 4000,
  parameter int FILL_TIMEOUT = 50000
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         H,
  input  logic                                         M,
  input  logic                                         L,
  input  logic                                         Ua,
  input  logic                                         T,
  input  logic [NZONES-1:0]                            Us,
  output logic                                         Ve,
  output logic [NZONES-1:0]                            Bs,
  output logic [NZONES-1:0]                            Vs,
  output logic                                         Al,
  output logic                                         E,
  output logic [(NZONES > 1 ? $clog2(NZONES) : 1)-1:0] zone
);
  localparam int ZW   = NZONES > 1 ? $clog2(NZONES) : 1;
  localparam int RMAX = SPR_CYC > DRIP_CYC ? SPR_CYC : DRIP_CYC;
  localparam int TW   = $clog2(RMAX + 1);
  localparam int SW   = NZONES + 5;
  typedef enum logic [1:0] {IDLE, SPRINKLE, DRIP, PAUSE} state_t;
  state_t st, nxt;
  logic [SW-1:0] s1, s2;
  logic [1:0] rdy;
  logic h_s, m_s, l_s, ua_s, t_s;
  logic [NZONES-1:0] us_s;
  logic [ZW-1:0] ptr_n, inc;
  logic [TW-1:0] tmr, tmr_n;
  logic to_hit, e_n, al_n, ve_n, wet;
  assign {h_s, m_s, l_s, ua_s, t_s, us_s} = s2;
`ifdef IRRIG_FILL_TIMEOUT_EN
  localparam int FW = $clog2(FILL_TIMEOUT + 1);
  logic [FW-1:0] fill;
  logic to_l;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fill <= '0;
      to_l <= 1'b0;
    end else if (rdy[1]) begin
      fill <= Ve ? fill + 1'b1 : '0;
      to_l <= to_hit;
    end
  assign to_hit = to_l | (Ve & (fill == FW'(FILL_TIMEOUT - 1)));
`else
  assign to_hit = 1'b0;
`endif
  always_comb begin
    e_n   = (h_s & ~m_s) | (m_s & ~l_s) | to_hit;
    al_n  = e_n | ~l_s;
    ve_n  = ~e_n & (~m_s | (Ve & ~h_s));
    wet   = us_s[zone];
    inc   = zone == ZW'(NZONES - 1) ? '0 : zone + 1'b1;
    nxt   = st;
    ptr_n = zone;
    tmr_n = tmr;
    case (st)
      IDLE:
        if (!al_n) begin
          if (wet) ptr_n = inc;
          else begin
            nxt   = (ua_s & t_s) ? DRIP : SPRINKLE;
            tmr_n = TW'(1);
          end
        end
      SPRINKLE, DRIP:
        if (al_n) begin
          nxt   = IDLE;
          tmr_n = '0;
        end else if (wet || tmr == (st == DRIP ? TW'(DRIP_CYC) : TW'(SPR_CYC))) begin
          nxt   = PAUSE;
          tmr_n = '0;
        end else tmr_n = tmr + 1'b1;
      default: begin
        nxt   = IDLE;
        ptr_n = inc;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      rdy  <= '0;
      st   <= IDLE;
      zone <= '0;
      tmr  <= '0;
      Ve   <= 1'b0;
      Al   <= 1'b0;
      E    <= 1'b0;
      Bs   <= '0;
      Vs   <= '0;
    end else begin
      s1  <= {H, M, L, Ua, T, Us};
      s2  <= s1;
      rdy <= {rdy[0], 1'b1};
      if (rdy[1]) begin
        st   <= nxt;
        zone <= ptr_n;
        tmr  <= tmr_n;
        Ve   <= ve_n;
        Al   <= al_n;
        E    <= e_n;
        Bs   <= nxt == SPRINKLE ? NZONES'(1) << ptr_n : '0;
        Vs   <= nxt == DRIP ? NZONES'(1) << ptr_n : '0;
      end
    end
endmodule

// File: tb/tb_irrigation_ctrl.sv
// tb_irrigation_ctrl: scoreboard bench for irrigation_ctrl with NZONES=2, SPR_CYC=4, DRIP_CYC=6, FILL_TIMEOUT=10
module tb_irrigation_ctrl;
  typedef struct {
    logic [7:0] v;
    logic [7:0] m;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic H = 1'b1, M = 1'b1, L = 1'b1, Ua = 1'b0, T = 1'b0;
  logic [1:0] Us = 2'b11;
  logic Ve, Al, E, zone;
  logic [1:0] Bs, Vs;
  int checks = 0, errors = 0;
  exp_t sb[$];
  wire [7:0] obs = {Ve, Al, E, Bs, Vs, zone};
  always #5 clk = ~clk;
  irrigation_ctrl #(.NZONES(2), .SPR_CYC(4), .DRIP_CYC(6), .FILL_TIMEOUT(10)) dut (
    .clk(clk), .rst_n(rst_n), .H(H), .M(M), .L(L), .Ua(Ua), .T(T), .Us(Us),
    .Ve(Ve), .Bs(Bs), .Vs(Vs), .Al(Al), .E(E), .zone(zone)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void push(input logic [7:0] v, input logic [7:0] m, input int n);
    repeat (n) sb.push_back('{v, m});
  endfunction
  task automatic set_lvl(input logic h, input logic m, input logic l);
    H = h;
    M = m;
    L = l;
  endtask
  task automatic do_reset(input logic h, input logic m, input logic l, input logic ua, input logic t, input logic [1:0] us);
    rst_n = 1'b0;
    set_lvl(h, m, l);
    Ua = ua;
    T  = t;
    Us = us;
    step();
    step();
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    exp_t e;
    int n = 0;
    push(8'h00, 8'hFF, 3);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n++;
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL reset_hold step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
      end
    end
    rst_n = 1'b1;
    push(8'h00, 8'hFF, 2);
    push(8'h01, 8'hFF, 1);
    push(8'h00, 8'hFF, 1);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n++;
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL reset_release step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
      end
    end
  endtask
  task automatic test_level();
    exp_t e;
    int n = 0;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin set_lvl(0, 0, 1); push(8'h00, 8'hFE, 2); push(8'h80, 8'hFE, 1); end
        1: begin set_lvl(0, 1, 1); push(8'h80, 8'hFE, 3); end
        2: begin set_lvl(1, 1, 1); push(8'h80, 8'hFE, 2); push(8'h00, 8'hFE, 1); end
        default: begin set_lvl(0, 1, 1); push(8'h00, 8'hFE, 3); end
      endcase
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n++;
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL level step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
        end
      end
    end
  endtask
  task automatic test_error();
    exp_t e;
    int n = 0;
    for (int s = 0; s < 4; s++) begin
      case (s)
        0: begin set_lvl(1, 0, 1); Us = 2'b00; push(8'h00, 8'hFE, 2); push(8'h60, 8'hFE, 1); end
        1: begin set_lvl(0, 1, 0); push(8'h60, 8'hFE, 3); end
        2: begin set_lvl(0, 0, 0); push(8'h60, 8'hFE, 2); push(8'hC0, 8'hFE, 1); end
        default: begin set_lvl(1, 1, 1); push(8'hC0, 8'hFE, 2); push(8'h00, 8'hE6, 1); end
      endcase
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n++;
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL error step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
        end
      end
    end
  endtask
  task automatic test_sprinkle();
    exp_t e;
    int n = 0;
    do_reset(1, 1, 1, 0, 0, 2'b10);
    push(8'h00, 8'hFF, 2);
    push(8'h08, 8'hFF, 4);
    push(8'h00, 8'hFF, 1);
    push(8'h01, 8'hFF, 1);
    push(8'h00, 8'hFF, 1);
    push(8'h08, 8'hFF, 1);
    while (sb.size() > 0) begin
      step();
      e = sb.pop_front();
      n++;
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL sprinkle step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
      end
    end
  endtask
  task automatic test_alarm();
    exp_t e;
    int n = 0;
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: push(8'h08, 8'hFF, 1);
        1: begin set_lvl(0, 0, 0); push(8'h08, 8'hFF, 2); push(8'hC0, 8'hFF, 2); end
        default: begin
          set_lvl(1, 1, 1);
          push(8'hC0, 8'hFF, 2);
          push(8'h08, 8'hFF, 4);
          push(8'h00, 8'hFF, 1);
          push(8'h01, 8'hFF, 1);
        end
      endcase
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n++;
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL alarm step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
        end
      end
    end
  endtask
  task automatic test_drip();
    exp_t e;
    int n = 0;
    do_reset(1, 1, 1, 1, 1, 2'b00);
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        push(8'h00, 8'hFF, 2);
        push(8'h02, 8'hFF, 6);
        push(8'h00, 8'hFF, 1);
        push(8'h01, 8'hFF, 1);
        push(8'h05, 8'hFF, 6);
        push(8'h01, 8'hFF, 1);
        push(8'h00, 8'hFF, 1);
        push(8'h02, 8'hFF, 1);
      end else begin
        Ua = 1'b0;
        push(8'h02, 8'hFF, 5);
        push(8'h00, 8'hFF, 1);
        push(8'h01, 8'hFF, 1);
        push(8'h11, 8'hFF, 1);
      end
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n++;
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL drip step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
        end
      end
    end
  endtask
  task automatic test_wet_stop();
    exp_t e;
    int n = 0;
    do_reset(1, 1, 1, 0, 0, 2'b00);
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        push(8'h00, 8'hFF, 2);
        push(8'h08, 8'hFF, 1);
      end else begin
        Us = 2'b01;
        push(8'h08, 8'hFF, 2);
        push(8'h00, 8'hFF, 1);
        push(8'h01, 8'hFF, 1);
        push(8'h11, 8'hFF, 1);
      end
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n++;
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL wet_stop step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
        end
      end
    end
  endtask
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: got %h want 00", obs);
    end
    step();
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL async_reset_hold: got %h want 00", obs);
    end
  endtask
  task automatic test_fill_timeout();
    exp_t e;
    int n = 0;
    do_reset(0, 0, 1, 0, 0, 2'b11);
    for (int s = 0; s < 2; s++) begin
      if (s == 0) begin
        push(8'h00, 8'hFE, 2);
        push(8'h80, 8'hFE, 10);
`ifdef IRRIG_FILL_TIMEOUT_EN
        push(8'h60, 8'hFE, 4);
`else
        push(8'h80, 8'hFE, 4);
`endif
      end else begin
        set_lvl(1, 1, 1);
`ifdef IRRIG_FILL_TIMEOUT_EN
        push(8'h60, 8'hFE, 4);
`else
        push(8'h80, 8'hFE, 2);
        push(8'h00, 8'hFE, 2);
`endif
      end
      while (sb.size() > 0) begin
        step();
        e = sb.pop_front();
        n++;
        checks++;
        if ((obs & e.m) !== (e.v & e.m)) begin
          errors++;
          $display("FAIL fill_timeout step %0d: got %h want %h mask %h", n, obs, e.v, e.m);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== 8'h00) begin
      errors++;
      $display("FAIL fill_timeout_reset: got %h want 00", obs);
    end
  endtask
  initial begin
    test_reset();
    test_level();
    test_error();
    test_sprinkle();
    test_alarm();
    test_drip();
    test_wet_stop();
    test_async_reset();
    test_fill_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
